// File: rtl/uart_byte_rx.sv
// Serial byte receiver: idle-high line, one-cycle start bit (or init mode), MSB-first data.
// A completed byte is offered through a one-entry valid/ready buffer with a sticky overrun flag.
module uart_byte_rx #(
  parameter int unsigned BYTE_SIZE = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 en,
  input  logic                 init_en,
  input  logic                 i_bit,
  output logic [BYTE_SIZE-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 overrun
);

  localparam int unsigned CNT_W = (BYTE_SIZE > 1) ? $clog2(BYTE_SIZE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTE_SIZE - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_DATA = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BYTE_SIZE-1:0] shreg_q, shreg_d;
  logic                 done_q, done_d;
  logic [BYTE_SIZE-1:0] out_data_d;
  logic                 out_valid_d;
  logic                 overrun_d;
  logic                 handshake_c;

  assign handshake_c = out_valid && out_ready;
  assign busy        = (state_q == ST_DATA);

  // State and datapath registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      done_q    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      done_q    <= done_d;
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
      overrun   <= overrun_d;
    end
  end

  // Next-state, shift register and output buffer logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    done_d      = 1'b0;
    out_data_d  = out_data;
    out_valid_d = out_valid;
    overrun_d   = overrun;

    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (init_en) begin
            state_d = ST_DATA;
            shreg_d = {shreg_q[BYTE_SIZE-2:0], i_bit};
            cnt_d   = CNT_W'(1);
          end else if (!i_bit) begin
            state_d = ST_DATA;
            cnt_d   = '0;
          end
        end
        ST_DATA: begin
          shreg_d = {shreg_q[BYTE_SIZE-2:0], i_bit};
          if (cnt_q == CNT_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // The assembled byte is presented one cycle after its LSB; the shift register
    // holds still during that cycle unless init mode starts the next byte.
    if (done_q) begin
      if (!out_valid || out_ready) begin
        out_data_d  = shreg_q;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (handshake_c) begin
      out_valid_d = 1'b0;
    end

    if (!en) begin
      overrun_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx: a table of framed bytes plus hand-built corner sequences.
module tb_uart_byte_rx;

  localparam int unsigned BS = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          en;
  logic          init_en;
  logic          i_bit;
  logic [BS-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          overrun;

  uart_byte_rx #(.BYTE_SIZE(BS)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .en        (en),
    .init_en   (init_en),
    .i_bit     (i_bit),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic          init;
    logic [BS-1:0] data;
    logic [BS-1:0] exp_data;
    int            exp_lat;
    int            exp_busy;
  } vec_t;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            busy_cnt = 0;
  logic [BS-1:0] cap_d[$];
  int            cap_t[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
    if (busy) busy_cnt++;
    if (out_valid && out_ready) begin
      cap_d.push_back(out_data);
      cap_t.push_back(cyc);
    end
  endtask

  task automatic send_bit(input logic b);
    i_bit = b;
    step();
  endtask

  task automatic send_frame(input logic init, input logic [BS-1:0] d);
    if (init) begin
      init_en = 1'b1;
      send_bit(d[BS-1]);
      init_en = 1'b0;
      for (int i = BS - 2; i >= 0; i--) send_bit(d[i]);
    end else begin
      send_bit(1'b0);
      for (int i = BS - 1; i >= 0; i--) send_bit(d[i]);
    end
    i_bit = 1'b1;
  endtask

  task automatic clear_caps();
    cap_d.delete();
    cap_t.delete();
    busy_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[6];

  initial begin
    int t_lsb;
    int t0;

    vecs[0] = '{init: 1'b0, data: 8'hA5, exp_data: 8'hA5, exp_lat: 1, exp_busy: 8};
    vecs[1] = '{init: 1'b1, data: 8'h81, exp_data: 8'h81, exp_lat: 1, exp_busy: 7};
    vecs[2] = '{init: 1'b0, data: 8'h7E, exp_data: 8'h7E, exp_lat: 1, exp_busy: 8};
    vecs[3] = '{init: 1'b0, data: 8'h00, exp_data: 8'h00, exp_lat: 1, exp_busy: 8};
    vecs[4] = '{init: 1'b0, data: 8'hFF, exp_data: 8'hFF, exp_lat: 1, exp_busy: 8};
    vecs[5] = '{init: 1'b1, data: 8'h3C, exp_data: 8'h3C, exp_lat: 1, exp_busy: 7};

    RST = 1'b0; en = 1'b1; init_en = 1'b0; i_bit = 1'b1; out_ready = 1'b1;
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_overrun",   32'(overrun),   32'd0);
    RST = 1'b1;
    step(); step();

    // Table: one framed byte per entry, consumer always ready
    foreach (vecs[v]) begin
      clear_caps();
      send_frame(vecs[v].init, vecs[v].data);
      t_lsb = cyc;
      check($sformatf("v%0d_busy_cycles", v), 32'(busy_cnt), 32'(vecs[v].exp_busy));
      check($sformatf("v%0d_no_early_valid", v), 32'(out_valid), 32'd0);
      for (int k = 0; k < 6 && cap_d.size() == 0; k++) step();
      step(); step();
      check($sformatf("v%0d_pulses", v), 32'(cap_d.size()), 32'd1);
      if (cap_d.size() > 0) begin
        check($sformatf("v%0d_data", v), 32'(cap_d[0]), 32'(vecs[v].exp_data));
        check($sformatf("v%0d_latency", v), 32'(cap_t[0] - t_lsb), 32'(vecs[v].exp_lat));
      end
      check($sformatf("v%0d_valid_drop", v), 32'(out_valid), 32'd0);
    end

    // Back-to-back frames with no idle gap
    clear_caps();
    t0 = cyc + 1;
    send_frame(1'b0, 8'h00);
    send_frame(1'b0, 8'hFF);
    send_frame(1'b0, 8'h3C);
    repeat (4) step();
    check("b2b_pulses", 32'(cap_d.size()), 32'd3);
    if (cap_d.size() == 3) begin
      check("b2b_d0", 32'(cap_d[0]), 32'h00);
      check("b2b_d1", 32'(cap_d[1]), 32'hFF);
      check("b2b_d2", 32'(cap_d[2]), 32'h3C);
      check("b2b_first_lat", 32'(cap_t[0] - t0), 32'd9);
      check("b2b_gap01", 32'(cap_t[1] - cap_t[0]), 32'd9);
      check("b2b_gap12", 32'(cap_t[2] - cap_t[1]), 32'd9);
    end
    check("b2b_overrun", 32'(overrun), 32'd0);

    // Backpressure then overrun
    out_ready = 1'b0;
    send_frame(1'b0, 8'h11);
    step(); step();
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_data",  32'(out_data),  32'h11);
    send_frame(1'b0, 8'h22);
    check("bp_no_overrun_yet", 32'(overrun), 32'd0);
    step();
    check("ovr_set",       32'(overrun),   32'd1);
    check("ovr_data_kept", 32'(out_data),  32'h11);
    check("ovr_valid",     32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("ovr_hs_valid",  32'(out_valid), 32'd0);
    check("ovr_hs_sticky", 32'(overrun),   32'd1);
    en = 1'b0;
    step();
    en = 1'b1;
    check("ovr_en_clear", 32'(overrun), 32'd0);

    // Handshake coincident with completion
    send_frame(1'b0, 8'h11);
    step();
    check("sim_pre_data", 32'(out_data), 32'h11);
    send_frame(1'b0, 8'h22);
    out_ready = 1'b1;
    step();
    check("sim_valid",   32'(out_valid), 32'd1);
    check("sim_data",    32'(out_data),  32'h22);
    check("sim_overrun", 32'(overrun),   32'd0);
    step();
    check("sim_consumed", 32'(out_valid), 32'd0);

    // Reset mid-byte with a byte held in the buffer
    out_ready = 1'b0;
    send_frame(1'b0, 8'hC3);
    step();
    send_bit(1'b0);
    for (int i = 7; i >= 4; i--) send_bit(1'(8'hA5 >> i));
    check("rst_abort_busy_pre", 32'(busy), 32'd1);
    RST = 1'b0;
    #1;
    check("rst_abort_valid",   32'(out_valid), 32'd0);
    check("rst_abort_data",    32'(out_data),  32'd0);
    check("rst_abort_busy",    32'(busy),      32'd0);
    check("rst_abort_overrun", 32'(overrun),   32'd0);
    i_bit = 1'b1;
    step();
    RST = 1'b1;
    out_ready = 1'b1;
    clear_caps();
    repeat (12) step();
    check("rst_abort_no_byte", 32'(cap_d.size()), 32'd0);

    // en-low abort, then a clean frame
    send_bit(1'b0);
    for (int i = 7; i >= 4; i--) send_bit(1'(8'hA5 >> i));
    en = 1'b0;
    step();
    en = 1'b1;
    check("en_abort_busy", 32'(busy), 32'd0);
    clear_caps();
    send_frame(1'b0, 8'h5A);
    repeat (4) step();
    check("en_abort_pulses", 32'(cap_d.size()), 32'd1);
    if (cap_d.size() > 0) check("en_abort_data", 32'(cap_d[0]), 32'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
